i2c_target: RTL and testbench

I2C target (slave) endpoint: the responder on the same two-wire bus that the team's `i2c` controller drives. It watches SCL/SDA, detects START/STOP, matches a programmable 7-bit address and ACKs it. On writes it hands received bytes to local logic; on reads it fetches bytes from local logic and shifts them out. Standard and fast mode only; no clock stretching, no general call, no 10-bit addressing.

---
 rtl/i2c_target_if.sv | 34 +++
 rtl/i2c_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// i2c_target_if: local-side bundle of the I2C target endpoint.
// The slave modport is the target; the master modport is the local logic.
interface i2c_target_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_req;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rd_nack;
    logic                  busy;

    modport master (
        output own_addr,
        output tx_data,
        input  tx_req,
        input  rx_data,
        input  rx_valid,
        input  rd_nack,
        input  busy
    );

    modport slave (
        input  own_addr,
        input  tx_data,
        output tx_req,
        output rx_data,
        output rx_valid,
        output rd_nack,
        output busy
    );
endinterface

// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint, 7-bit address, no clock stretching.
// Conditions SCL/SDA, detects START/STOP, moves bytes to/from local logic.
module i2c_target #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire         sda,
    inout  wire         scl,
    i2c_target_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] RW_BIT    = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] FULL      = CW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;
    logic scl_rise_d, scl_fall_d, start_d, stop_d;
    logic scl_rise_q, scl_fall_q, start_q, stop_q;

    state_t                state_d, state_q;
    logic [CW-1:0]         bit_cnt_d, bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_d, shift_q;
    logic                  rw_d, rw_q;
    logic                  match_d, match_q;
    logic                  ack_seen_d, ack_seen_q;
    logic                  sda_oe_d, sda_oe_q;
    logic                  busy_d, busy_q;
    logic [DATA_WIDTH-1:0] rx_data_d, rx_data_q;
    logic                  rx_valid_d, rx_valid_q;
    logic                  rd_nack_d, rd_nack_q;
    logic                  tx_load;

    // Open-drain pins: SDA is only ever pulled low, SCL is never driven.
    assign sda = sda_oe_q ? 1'b0 : 1'bz;
    assign scl = 1'bz;

    assign bus.tx_req   = tx_load;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rd_nack  = rd_nack_q;
    assign bus.busy     = busy_q;

    // Edge and bus-condition detection on the synchronized pin values.
    always_comb begin
        scl_rise_d = scl_s2_q & ~scl_h_q;
        scl_fall_d = ~scl_s2_q & scl_h_q;
        start_d    = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
        stop_d     = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;
    end

    // Pin synchronizers plus history; idle bus level is high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_h_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_h_q    <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl;
            scl_s2_q   <= scl_s1_q;
            scl_h_q    <= scl_s2_q;
            sda_s1_q   <= sda;
            sda_s2_q   <= sda_s1_q;
            sda_h_q    <= sda_s2_q;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // Protocol FSM: START/STOP first, then per-state bit handling.
    // sda_h_q is the SDA level aligned with the registered SCL strobes.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        match_d    = match_q;
        ack_seen_d = ack_seen_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_nack_d  = 1'b0;
        tx_load    = 1'b0;

        if (start_q) begin
            state_d    = ADDR;
            bit_cnt_d  = '0;
            shift_d    = '0;
            match_d    = 1'b0;
            ack_seen_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else if (stop_q) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            ack_seen_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                ADDR: begin
                    if (scl_rise_q) begin
                        shift_d   = {shift_q[DATA_WIDTH-2:0], sda_h_q};
                        bit_cnt_d = bit_cnt_q + ONE;
                        if (bit_cnt_q == ADDR_LAST) begin
                            match_d = ({shift_q[ADDR_WIDTH-2:0], sda_h_q}
                                       == bus.own_addr);
                        end
                        if (bit_cnt_q == RW_BIT) begin
                            rw_d       = sda_h_q;
                            bit_cnt_d  = '0;
                            ack_seen_d = 1'b0;
                            state_d    = match_q ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_q) begin
                        if (!ack_seen_q) begin
                            ack_seen_d = 1'b1;
                            sda_oe_d   = 1'b1;
                            busy_d     = 1'b1;
                        end else begin
                            ack_seen_d = 1'b0;
                            bit_cnt_d  = '0;
                            if (rw_q) begin
                                tx_load   = 1'b1;
                                shift_d   = bus.tx_data;
                                sda_oe_d  = ~bus.tx_data[DATA_WIDTH-1];
                                bit_cnt_d = ONE;
                                state_d   = RD_DATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise_q && bit_cnt_q != FULL) begin
                        shift_d   = {shift_q[DATA_WIDTH-2:0], sda_h_q};
                        bit_cnt_d = bit_cnt_q + ONE;
                    end else if (scl_fall_q && bit_cnt_q == FULL) begin
                        sda_oe_d   = 1'b1;
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall_q) begin
                        if (bit_cnt_q == FULL) begin
                            sda_oe_d   = 1'b0;
                            bit_cnt_d  = '0;
                            ack_seen_d = 1'b0;
                            state_d    = RD_ACK;
                        end else begin
                            shift_d   = shift_q << 1;
                            sda_oe_d  = ~shift_q[DATA_WIDTH-2];
                            bit_cnt_d = bit_cnt_q + ONE;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise_q) begin
                        if (sda_h_q) begin
                            rd_nack_d = 1'b1;
                            state_d   = WAIT_STOP;
                        end else begin
                            ack_seen_d = 1'b1;
                        end
                    end else if (scl_fall_q && ack_seen_q) begin
                        ack_seen_d = 1'b0;
                        tx_load    = 1'b1;
                        shift_d    = bus.tx_data;
                        sda_oe_d   = ~bus.tx_data[DATA_WIDTH-1];
                        bit_cnt_d  = ONE;
                        state_d    = RD_DATA;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state and datapath registers; reset releases SDA at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            match_q    <= 1'b0;
            ack_seen_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_nack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            match_q    <= match_d;
            ack_seen_q <= ack_seen_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_nack_q  <= rd_nack_d;
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller with scoreboards for the
// written and read bytes of the i2c_target endpoint.
module tb_i2c_target;
    localparam int Q = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sda_lo = 1'b0;
    logic scl_lo = 1'b0;
    wire  sda_bus;
    wire  scl_bus;

    pullup (sda_bus);
    pullup (scl_bus);
    assign sda_bus = sda_lo ? 1'b0 : 1'bz;
    assign scl_bus = scl_lo ? 1'b0 : 1'bz;

    i2c_target_if bus ();

    i2c_target dut (
        .clock (clock),
        .reset (reset),
        .sda   (sda_bus),
        .scl   (scl_bus),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    int n_rxv = 0;
    int n_txreq = 0;
    int n_nack = 0;
    int n_busy = 0;
    int n_drive = 0;
    int n_overlap = 0;
    logic tx_fresh = 1'b0;
    logic [7:0] rx_exp[$];
    logic [7:0] rd_exp[$];
    logic [7:0] tx_src[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: scoreboards, pulse counters, supplies tx_data after each tx_req.
    always begin
        @(negedge clock);
        #2;
        if (reset) begin
            if (bus.rx_valid) begin
                n_rxv++;
                if (rx_exp.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_data", bus.rx_data, rx_exp.pop_front());
            end
            if (bus.tx_req) begin
                n_txreq++;
                rd_exp.push_back(bus.tx_data);
                tx_fresh = 1'b0;
            end else if (!tx_fresh && tx_src.size() > 0) begin
                bus.tx_data = tx_src.pop_front();
                tx_fresh = 1'b1;
            end
            if (bus.rd_nack) n_nack++;
            if (bus.busy) n_busy++;
            if (!sda_lo && sda_bus === 1'b0) n_drive++;
            if (bus.rx_valid && bus.tx_req) n_overlap++;
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clock);
    endtask

    task automatic bit_io(input logic b, output logic r);
        sda_lo = ~b;
        wait_q();
        scl_lo = 1'b0;
        wait_q();
        r = sda_bus;
        wait_q();
        scl_lo = 1'b1;
        wait_q();
    endtask

    task automatic start_c();
        sda_lo = 1'b0;
        wait_q();
        scl_lo = 1'b0;
        wait_q();
        sda_lo = 1'b1;
        wait_q();
        scl_lo = 1'b1;
        wait_q();
    endtask

    task automatic stop_c();
        sda_lo = 1'b1;
        wait_q();
        scl_lo = 1'b0;
        wait_q();
        sda_lo = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(d[i], r);
        bit_io(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            d[i] = r;
        end
        bit_io(nack, r);
    endtask

    task automatic read_check(input string tag, input logic nack);
        logic [7:0] d;
        read_byte(nack, d);
        if (rd_exp.size() == 0) check({tag, "_unexpected"}, 1, 0);
        else check(tag, d, rd_exp.pop_front());
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic ack;
        int rxv0, txr0, nck0, drv0, bsy0;

        bus.own_addr = 7'h42;
        repeat (3) @(negedge clock);
        check("rst_sda", sda_bus, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_pulses", {bus.rx_valid, bus.tx_req, bus.rd_nack}, 0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // Write 0x5A to 0x42
        rxv0 = n_rxv;
        start_c();
        send_byte({7'h42, 1'b0}, ack);
        check("t1_addr_ack", ack, 0);
        rx_exp.push_back(8'h5A);
        send_byte(8'h5A, ack);
        check("t1_data_ack", ack, 0);
        check("t1_busy", bus.busy, 1);
        stop_c();
        check("t1_busy_stop", bus.busy, 0);
        check("t1_rx_count", n_rxv - rxv0, 1);
        check("t1_rx_data", bus.rx_data, 8'h5A);

        // Two-byte read, ACK then NACK
        txr0 = n_txreq;
        nck0 = n_nack;
        tx_src.push_back(8'hC3);
        tx_src.push_back(8'h3C);
        start_c();
        send_byte({7'h42, 1'b1}, ack);
        check("t2_addr_ack", ack, 0);
        read_check("t2_rd0", 1'b0);
        read_check("t2_rd1", 1'b1);
        check("t2_sda_free", sda_bus, 1);
        stop_c();
        check("t2_tx_req_count", n_txreq - txr0, 2);
        check("t2_nack_count", n_nack - nck0, 1);

        // Address mismatch
        rxv0 = n_rxv;
        drv0 = n_drive;
        bsy0 = n_busy;
        start_c();
        send_byte({7'h43, 1'b0}, ack);
        check("t3_addr_nack", ack, 1);
        send_byte(8'h5A, ack);
        check("t3_data_nack", ack, 1);
        stop_c();
        check("t3_sda_driven", n_drive - drv0, 0);
        check("t3_rx_count", n_rxv - rxv0, 0);
        check("t3_busy_cycles", n_busy - bsy0, 0);

        // Repeated START: write then read
        tx_src.push_back(8'hA5);
        rx_exp.push_back(8'h11);
        start_c();
        send_byte({7'h42, 1'b0}, ack);
        check("t4_addr_ack", ack, 0);
        send_byte(8'h11, ack);
        check("t4_data_ack", ack, 0);
        start_c();
        check("t4_sr_busy", bus.busy, 0);
        send_byte({7'h42, 1'b1}, ack);
        check("t4_raddr_ack", ack, 0);
        check("t4_rx_data", bus.rx_data, 8'h11);
        read_check("t4_rd", 1'b1);
        stop_c();

        // STOP after four data bits
        rxv0 = n_rxv;
        start_c();
        send_byte({7'h42, 1'b0}, ack);
        check("t5_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) bit_io(i[0], ack);
        stop_c();
        check("t5_rx_count", n_rxv - rxv0, 0);
        check("t5_busy", bus.busy, 0);
        rx_exp.push_back(8'h99);
        start_c();
        send_byte({7'h42, 1'b0}, ack);
        check("t5_next_ack", ack, 0);
        send_byte(8'h99, ack);
        check("t5_next_data_ack", ack, 0);
        stop_c();
        check("t5_rx_data", bus.rx_data, 8'h99);

        // Reset while the target drives a 0 bit
        tx_src.push_back(8'h00);
        start_c();
        send_byte({7'h42, 1'b1}, ack);
        check("t6_addr_ack", ack, 0);
        wait_q();
        check("t6_drive_low", sda_bus, 0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_release", sda_bus, 1);
        check("t6_busy", bus.busy, 0);
        check("t6_rx_data", bus.rx_data, 0);
        check("t6_pulses", {bus.rx_valid, bus.tx_req, bus.rd_nack}, 0);
        @(negedge clock);
        reset = 1'b1;
        stop_c();
        rd_exp.delete();

        check("end_rx_left", rx_exp.size(), 0);
        check("end_overlap", n_overlap, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
